// File: rtl/insn_encoder.sv
// Instruction encoder: packs op/ra/rb/rc/imm fields into 16-bit words, buffers them and streams them to imem.
// Latency: one cycle minimum from the accepting edge to imem_we. Backpressure: imem_stall freezes the buffer and in_ready drops when it is full.
// Optional IMM_CHECK_EN: out-of-range immediates are consumed but dropped, and the sticky err flag is set.

module insn_encoder_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdat;
    end

    // The extra pointer bit tells full apart from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdat  = mem[rd_ptr[AW-1:0]];
endmodule

module insn_encoder #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_ra,
    input  logic [2:0]  in_rb,
    input  logic [2:0]  in_rc,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    input  logic        imem_stall,
    output logic        done,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [15:0] enc_word;
    logic [15:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        imm_ok;

    always_comb begin
        enc_word = {in_op, in_ra, in_rb, in_imm[6:0]};
        case (in_op)
            3'b000, 3'b010: enc_word = {in_op, in_ra, in_rb, 4'b0000, in_rc};
            3'b011:         enc_word = {in_op, in_ra, in_imm[9:0]};
            3'b111:         enc_word = {in_op, in_ra, in_rb, 7'b0000000};
            default:        enc_word = {in_op, in_ra, in_rb, in_imm[6:0]};
        endcase
    end

`ifdef IMM_CHECK_EN
    // Reg-reg-imm forms take a signed 7-bit immediate, LUI an unsigned 10-bit one.
    always_comb begin
        imm_ok = 1'b1;
        case (in_op)
            3'b001, 3'b100, 3'b101, 3'b110: imm_ok = (in_imm[15:6] == 10'h000) || (in_imm[15:6] == 10'h3FF);
            3'b011:                         imm_ok = (in_imm[15:10] == 6'h00);
            default:                        imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign in_ready   = !rst && (state == S_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && imm_ok;
    assign imem_we    = !rst && !fifo_empty && !imem_stall;
    assign imem_wdata = fifo_empty ? 16'h0000 : fifo_head;

    insn_encoder_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (imem_we),
        .wdat  (enc_word),
        .rdat  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_addr <= BASE_ADDR;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (imem_we) imem_addr <= imem_addr + 16'd1;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        imem_addr <= BASE_ADDR;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!imm_ok) err <= 1'b1;
                        if (in_last) state <= S_DRAIN;
                    end
                end
                // An empty buffer also means no write is in flight this cycle.
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
